// File: rtl/mem_arbiter.sv
// Arbitrates the byte-serial memory controller between fetch and load/store.
// Optional starvation guard for fetch is enabled by defining STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] IO_ADDR_BASE = 32'h30000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        iIO_buffer_full,
    input  logic        iFLUSH,
    input  logic        iIF_en,
    input  logic [31:0] iIF_addr,
    output logic        oIF_done,
    output logic [31:0] oIF_inst,
    input  logic        iLS_en,
    input  logic        iLS_ls,
    input  logic [2:0]  iLS_len,
    input  logic [31:0] iLS_addr,
    input  logic [31:0] iLS_dt,
    output logic        oLS_done,
    output logic [31:0] oLS_dt,
    output logic        oMC_en,
    output logic        oMC_ls,
    output logic [2:0]  oMC_len,
    output logic [31:0] oMC_addr,
    output logic [31:0] oMC_dt,
    input  logic        iMC_done,
    input  logic [31:0] iMC_dt
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, DRAIN} state_t;

    state_t      state, state_n;
    logic        ls_hold, ls_elig, if_elig, starve;
    logic        gnt_ls, gnt_if, can_grant;
    logic        mc_en_n, mc_ls_n, if_done_n, ls_done_n;
    logic [2:0]  mc_len_n;
    logic [31:0] mc_addr_n, mc_dt_n, if_inst_n, ls_dt_n, len_mask;

    assign ls_hold = iLS_ls && (iLS_addr >= IO_ADDR_BASE) && iIO_buffer_full;
    assign ls_elig = iLS_en && !ls_hold;
    assign if_elig = iIF_en && !iFLUSH;

`ifdef STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;
    assign starve = (starve_cnt >= CW'(STARVE_LIMIT));
`else
    assign starve = 1'b0;
`endif

    // Owner still sees its done pulse this cycle and may hold en; skip a grant.
    assign can_grant = (state == IDLE) && !oIF_done && !oLS_done;
    assign gnt_ls    = can_grant && ls_elig && !(starve && if_elig);
    assign gnt_if    = can_grant && if_elig && !gnt_ls;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            oMC_en   <= 1'b0;
            oMC_ls   <= 1'b0;
            oMC_len  <= 3'd0;
            oMC_addr <= 32'd0;
            oMC_dt   <= 32'd0;
            oIF_done <= 1'b0;
            oIF_inst <= 32'd0;
            oLS_done <= 1'b0;
            oLS_dt   <= 32'd0;
        end else if (rdy) begin
            state    <= state_n;
            oMC_en   <= mc_en_n;
            oMC_ls   <= mc_ls_n;
            oMC_len  <= mc_len_n;
            oMC_addr <= mc_addr_n;
            oMC_dt   <= mc_dt_n;
            oIF_done <= if_done_n;
            oIF_inst <= if_inst_n;
            oLS_done <= ls_done_n;
            oLS_dt   <= ls_dt_n;
        end
    end

`ifdef STARVE_GUARD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (rdy) begin
            if (gnt_if) begin
                starve_cnt <= '0;
            end else if (gnt_ls && iIF_en && !starve) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (gnt_ls) begin
                    state_n = BUSY_LS;
                end else if (gnt_if) begin
                    state_n = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (iMC_done) begin
                    state_n = IDLE;
                end else if (iFLUSH) begin
                    state_n = DRAIN;
                end
            end
            BUSY_LS, DRAIN: begin
                if (iMC_done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        len_mask = 32'hFFFF_FFFF;
        unique case (oMC_len)
            3'd1:    len_mask = 32'h0000_00FF;
            3'd2:    len_mask = 32'h0000_FFFF;
            default: len_mask = 32'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        mc_en_n   = oMC_en;
        mc_ls_n   = oMC_ls;
        mc_len_n  = oMC_len;
        mc_addr_n = oMC_addr;
        mc_dt_n   = oMC_dt;
        if_done_n = 1'b0;
        if_inst_n = oIF_inst;
        ls_done_n = 1'b0;
        ls_dt_n   = oLS_dt;
        if (gnt_ls) begin
            mc_en_n   = 1'b1;
            mc_ls_n   = iLS_ls;
            mc_len_n  = iLS_len;
            mc_addr_n = iLS_addr;
            mc_dt_n   = iLS_ls ? iLS_dt : 32'd0;
        end else if (gnt_if) begin
            mc_en_n   = 1'b1;
            mc_ls_n   = 1'b0;
            mc_len_n  = 3'd4;
            mc_addr_n = iIF_addr;
            mc_dt_n   = 32'd0;
        end
        if (state != IDLE && iMC_done) begin
            mc_en_n = 1'b0;
            if (state == BUSY_IF && !iFLUSH) begin
                if_done_n = 1'b1;
                if_inst_n = iMC_dt;
            end
            if (state == BUSY_LS) begin
                ls_done_n = 1'b1;
                ls_dt_n   = iMC_dt & len_mask;
            end
        end
    end

endmodule
